// File: rtl/regfile_mover.sv
// Block copy / block fill sequencer driving a single-port register file.
// Copy reads one word then writes it (2 cycles/word); fill writes one word per cycle.
module regfile_mover #(
  parameter int DATA_WIDTH      = 8,
  parameter int DATA_ADDR_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_start,
  input  logic                       i_mode,
  input  logic [DATA_ADDR_WIDTH-1:0] i_src_addr,
  input  logic [DATA_ADDR_WIDTH-1:0] i_dst_addr,
  input  logic [DATA_ADDR_WIDTH:0]   i_length,
  input  logic [DATA_WIDTH-1:0]      i_fill_data,
  input  logic                       i_abort,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [DATA_ADDR_WIDTH-1:0] o_rf_address,
  output logic [DATA_WIDTH-1:0]      o_rf_data,
  output logic                       o_rf_write_en,
  input  logic [DATA_WIDTH-1:0]      i_rf_data
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e                     r_state;
  logic                       r_mode;
  logic [DATA_ADDR_WIDTH-1:0] r_src_ptr;
  logic [DATA_ADDR_WIDTH-1:0] r_dst_ptr;
  logic [DATA_ADDR_WIDTH:0]   r_cnt;
  logic [DATA_WIDTH-1:0]      r_buf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_mode    <= 1'b0;
      r_src_ptr <= '0;
      r_dst_ptr <= '0;
      r_cnt     <= '0;
      r_buf     <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_mode    <= i_mode;
            r_src_ptr <= i_src_addr;
            r_dst_ptr <= i_dst_addr;
            r_cnt     <= i_length;
            if (i_mode) r_buf <= i_fill_data;
            if (i_length == '0) r_state <= StDone;
            else if (i_mode)    r_state <= StWr;
            else                r_state <= StRd;
          end
        end
        StRd: begin
          if (i_abort) begin
            r_state <= StIdle;
          end else begin
            r_buf     <= i_rf_data;
            r_src_ptr <= r_src_ptr + DATA_ADDR_WIDTH'(1);
            r_state   <= StWr;
          end
        end
        StWr: begin
          // The write commits at this edge even when aborting.
          if (i_abort) begin
            r_state <= StIdle;
          end else begin
            r_dst_ptr <= r_dst_ptr + DATA_ADDR_WIDTH'(1);
            r_cnt     <= r_cnt - (DATA_ADDR_WIDTH + 1)'(1);
            if (r_cnt == (DATA_ADDR_WIDTH + 1)'(1)) r_state <= StDone;
            else if (r_mode)                         r_state <= StWr;
            else                                     r_state <= StRd;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  // Moore decode: outputs depend on registered state only.
  always_comb begin
    o_busy        = 1'b0;
    o_done        = 1'b0;
    o_rf_write_en = 1'b0;
    o_rf_address  = '0;
    o_rf_data     = '0;
    unique case (r_state)
      StIdle: ;
      StRd: begin
        o_busy       = 1'b1;
        o_rf_address = r_src_ptr;
      end
      StWr: begin
        o_busy        = 1'b1;
        o_rf_write_en = 1'b1;
        o_rf_address  = r_dst_ptr;
        o_rf_data     = r_buf;
      end
      StDone: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_mover.sv
// Directed bench for regfile_mover with a behavioural register file attached.
module tb_regfile_mover;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_mode = 1'b0;
  logic [4:0] i_src_addr = '0;
  logic [4:0] i_dst_addr = '0;
  logic [5:0] i_length = '0;
  logic [7:0] i_fill_data = '0;
  logic       i_abort = 1'b0;
  logic       o_busy, o_done, o_rf_write_en;
  logic [4:0] o_rf_address;
  logic [7:0] o_rf_data;
  logic [7:0] i_rf_data;

  logic [7:0] mem [32] = '{default: 8'h00};
  logic       tb_we = 1'b0;
  logic [4:0] tb_a = '0;
  logic [7:0] tb_d = '0;
  logic       log_clr = 1'b0;

  logic [4:0] wr_a [$];
  logic [7:0] wr_d [$];
  int         wr_c [$];
  logic [4:0] ad_q [$];
  int         cyc = 0;
  int         start_cyc = 0;
  int         done_cyc = 0;
  int         done_cnt = 0;

  int total = 0;
  int bad = 0;

  regfile_mover #(.DATA_WIDTH(8), .DATA_ADDR_WIDTH(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_mode       (i_mode),
    .i_src_addr   (i_src_addr),
    .i_dst_addr   (i_dst_addr),
    .i_length     (i_length),
    .i_fill_data  (i_fill_data),
    .i_abort      (i_abort),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_rf_address (o_rf_address),
    .o_rf_data    (o_rf_data),
    .o_rf_write_en(o_rf_write_en),
    .i_rf_data    (i_rf_data)
  );

  always #5 clk = ~clk;

  assign i_rf_data = mem[o_rf_address];

  always @(posedge clk) begin
    if (o_rf_write_en) mem[o_rf_address] <= o_rf_data;
    else if (tb_we)    mem[tb_a] <= tb_d;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (log_clr) begin
      wr_a.delete(); wr_d.delete(); wr_c.delete(); ad_q.delete();
      done_cnt <= 0;
    end else begin
      if (o_rf_write_en) begin
        wr_a.push_back(o_rf_address); wr_d.push_back(o_rf_data); wr_c.push_back(cyc);
      end
      if (o_busy && !o_done) ad_q.push_back(o_rf_address);
      if (i_start && !o_busy && rst_n) start_cyc <= cyc;
      if (o_done) begin
        done_cyc <= cyc;
        done_cnt <= done_cnt + 1;
      end
    end
  end

  task automatic poke(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk); tb_we = 1'b1; tb_a = a; tb_d = d;
    @(posedge clk); #1 tb_we = 1'b0;
  endtask

  task automatic clear_log();
    @(negedge clk); log_clr = 1'b1;
    @(posedge clk); #1 log_clr = 1'b0;
  endtask

  task automatic start_cmd(input logic m, input logic [4:0] s, input logic [4:0] d,
                           input logic [5:0] n, input logic [7:0] f);
    @(negedge clk);
    i_start = 1'b1; i_mode = m; i_src_addr = s; i_dst_addr = d; i_length = n; i_fill_data = f;
    @(posedge clk); #1 i_start = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    #3;
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", o_busy); end
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", o_done); end
    total++; if (o_rf_write_en !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", o_rf_write_en); end
    total++; if (o_rf_address !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", o_rf_address); end
    total++; if (o_rf_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%0h want=0", o_rf_data); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_fill();
    poke(5'd3, 8'h33); poke(5'd7, 8'h77);
    clear_log();
    start_cmd(1'b1, 5'd0, 5'd4, 6'd3, 8'hA5);
    run(6);
    total++; if (wr_a.size() !== 3) begin bad++; $display("FAIL fill_count got=%0d want=3", wr_a.size()); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (wr_a[i] !== 5'(4 + i) || wr_d[i] !== 8'hA5) begin
        bad++; $display("FAIL fill_write%0d got=%0d/%0h want=%0d/a5", i, wr_a[i], wr_d[i], 4 + i);
      end
    end
    total++; if (wr_c[2] - wr_c[0] !== 2) begin bad++; $display("FAIL fill_consecutive got=%0d want=2", wr_c[2] - wr_c[0]); end
    total++; if (done_cyc - start_cyc !== 4) begin bad++; $display("FAIL fill_latency got=%0d want=4", done_cyc - start_cyc); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL fill_done_cnt got=%0d want=1", done_cnt); end
    total++; if (mem[3] !== 8'h33 || mem[7] !== 8'h77) begin
      bad++; $display("FAIL fill_neighbours got=%0h,%0h want=33,77", mem[3], mem[7]);
    end
  endtask

  task automatic test_copy();
    logic [4:0] ea [8] = '{5'd0, 5'd16, 5'd1, 5'd17, 5'd2, 5'd18, 5'd3, 5'd19};
    logic [7:0] ed [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) poke(5'(i), ed[i]);
    clear_log();
    start_cmd(1'b0, 5'd0, 5'd16, 6'd4, 8'hFF);
    run(11);
    total++; if (ad_q.size() !== 8) begin bad++; $display("FAIL copy_addr_count got=%0d want=8", ad_q.size()); end
    for (int i = 0; i < 8; i++) begin
      total++; if (ad_q[i] !== ea[i]) begin bad++; $display("FAIL copy_addr%0d got=%0d want=%0d", i, ad_q[i], ea[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (mem[16 + i] !== ed[i]) begin bad++; $display("FAIL copy_mem%0d got=%0h want=%0h", 16 + i, mem[16 + i], ed[i]); end
    end
    total++; if (done_cyc - start_cyc !== 9) begin bad++; $display("FAIL copy_latency got=%0d want=9", done_cyc - start_cyc); end
  endtask

  task automatic test_wrap_overlap();
    // Word 0 is overwritten before it is read back, so it propagates to word 2.
    logic [4:0] ea [8] = '{5'd30, 5'd0, 5'd31, 5'd1, 5'd0, 5'd2, 5'd1, 5'd3};
    logic [7:0] ed [4] = '{8'hA0, 8'hA1, 8'hA0, 8'hA1};
    poke(5'd30, 8'hA0); poke(5'd31, 8'hA1); poke(5'd0, 8'hB0); poke(5'd1, 8'hB1);
    clear_log();
    start_cmd(1'b0, 5'd30, 5'd0, 6'd4, 8'h00);
    run(11);
    for (int i = 0; i < 8; i++) begin
      total++; if (ad_q[i] !== ea[i]) begin bad++; $display("FAIL wrap_addr%0d got=%0d want=%0d", i, ad_q[i], ea[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (mem[i] !== ed[i]) begin bad++; $display("FAIL wrap_mem%0d got=%0h want=%0h", i, mem[i], ed[i]); end
    end
    poke(5'd0, 8'h07); poke(5'd1, 8'h01); poke(5'd2, 8'h02); poke(5'd3, 8'h03);
    start_cmd(1'b0, 5'd0, 5'd1, 6'd3, 8'h00);
    run(9);
    for (int i = 1; i < 4; i++) begin
      total++; if (mem[i] !== 8'h07) begin bad++; $display("FAIL overlap_mem%0d got=%0h want=07", i, mem[i]); end
    end
  endtask

  task automatic test_boundaries();
    bit seen [32];
    logic [7:0] m;
    clear_log();
    start_cmd(1'b0, 5'd2, 5'd9, 6'd0, 8'h00);
    run(3);
    total++; if (wr_a.size() !== 0) begin bad++; $display("FAIL len0_writes got=%0d want=0", wr_a.size()); end
    total++; if (done_cyc - start_cyc !== 1) begin bad++; $display("FAIL len0_latency got=%0d want=1", done_cyc - start_cyc); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL len0_done_cnt got=%0d want=1", done_cnt); end
    clear_log();
    start_cmd(1'b1, 5'd0, 5'd7, 6'd32, 8'h5C);
    run(36);
    total++; if (wr_a.size() !== 32) begin bad++; $display("FAIL len32_writes got=%0d want=32", wr_a.size()); end
    foreach (wr_a[i]) seen[wr_a[i]] = 1'b1;
    for (int i = 0; i < 32; i++) begin
      m = mem[i];
      total++;
      if (!seen[i] || m !== 8'h5C) begin bad++; $display("FAIL len32_word%0d got=%0h seen=%0d want=5c", i, m, seen[i]); end
    end
    total++; if (done_cyc - start_cyc !== 33) begin bad++; $display("FAIL len32_latency got=%0d want=33", done_cyc - start_cyc); end
  endtask

  task automatic test_collisions();
    poke(5'd20, 8'h00); poke(5'd21, 8'h00); poke(5'd14, 8'h00);
    clear_log();
    start_cmd(1'b1, 5'd0, 5'd8, 6'd3, 8'h11);
    @(negedge clk);
    i_start = 1'b1; i_mode = 1'b1; i_dst_addr = 5'd20; i_length = 6'd2; i_fill_data = 8'h22;
    @(posedge clk); #1 i_start = 1'b0;
    run(3);
    total++; if (o_done !== 1'b1) begin bad++; $display("FAIL coll_done_cycle got=%b want=1", o_done); end
    i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    run(4);
    total++; if (wr_a.size() !== 3) begin bad++; $display("FAIL coll_writes got=%0d want=3", wr_a.size()); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (wr_a[i] !== 5'(8 + i) || wr_d[i] !== 8'h11) begin
        bad++; $display("FAIL coll_write%0d got=%0d/%0h want=%0d/11", i, wr_a[i], wr_d[i], 8 + i);
      end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL coll_done_cnt got=%0d want=1", done_cnt); end
    total++; if (mem[20] !== 8'h00) begin bad++; $display("FAIL coll_mem20 got=%0h want=00", mem[20]); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL coll_idle got=%b want=0", o_busy); end
    // Abort raised during the second WR cycle of a five-word fill.
    clear_log();
    start_cmd(1'b1, 5'd0, 5'd12, 6'd5, 8'h3C);
    @(negedge clk);
    @(negedge clk); i_abort = 1'b1;
    @(posedge clk); #1 i_abort = 1'b0;
    run(8);
    total++; if (wr_a.size() !== 2) begin bad++; $display("FAIL abort_writes got=%0d want=2", wr_a.size()); end
    total++; if (wr_a[0] !== 5'd12 || wr_a[1] !== 5'd13) begin
      bad++; $display("FAIL abort_addrs got=%0d,%0d want=12,13", wr_a[0], wr_a[1]);
    end
    total++; if (mem[14] !== 8'h00) begin bad++; $display("FAIL abort_mem14 got=%0h want=00", mem[14]); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b want=0", o_busy); end
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", done_cnt); end
  endtask

  task automatic test_async_reset();
    start_cmd(1'b0, 5'd0, 5'd16, 6'd4, 8'h00);
    @(negedge clk);
    @(negedge clk);
    total++; if (o_rf_write_en !== 1'b1) begin bad++; $display("FAIL ares_pre_we got=%b want=1", o_rf_write_en); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL ares_busy got=%b want=0", o_busy); end
    total++; if (o_rf_write_en !== 1'b0) begin bad++; $display("FAIL ares_we got=%b want=0", o_rf_write_en); end
    total++; if (o_rf_address !== 5'd0) begin bad++; $display("FAIL ares_addr got=%0d want=0", o_rf_address); end
    @(negedge clk); rst_n = 1'b1;
    clear_log();
    start_cmd(1'b1, 5'd0, 5'd25, 6'd2, 8'h66);
    run(5);
    total++; if (wr_a.size() !== 2) begin bad++; $display("FAIL ares_new_writes got=%0d want=2", wr_a.size()); end
    total++; if (mem[25] !== 8'h66 || mem[26] !== 8'h66) begin
      bad++; $display("FAIL ares_new_mem got=%0h,%0h want=66,66", mem[25], mem[26]);
    end
    total++; if (done_cyc - start_cyc !== 3) begin bad++; $display("FAIL ares_new_latency got=%0d want=3", done_cyc - start_cyc); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_copy();
    test_wrap_overlap();
    test_boundaries();
    test_collisions();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
